mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multi-cycle access sequencer between the processor control/datapath and the byte-addressable unified memory.
- Serialises instruction fetches, loads and stores into single-requester memory transactions and drives MemRead/MemWrite/IorD to the memory.
- Latches the fetched instruction and load data, performs sign/zero extension, and builds sub-doubleword stores by read-modify-write, because the memory always writes 8 bytes.
- Flags misaligned, out-of-range and text-region-write accesses.

Parameters:
- MEM_SIZE, 12288, total memory bytes; must match the memory instance.
- TEXT_SIZE, 4096, bytes [0, TEXT_SIZE) are instruction space; stores there fault.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe; sampled only when req_ready=1
- req_ready  out  1  high only in IDLE
- req_op  in  2  00 fetch, 01 load, 10 store, 11 reserved (faults)
- req_funct3  in  3  RV64 width/sign code (loads 000-110, stores 000-011)
- req_addr  in  64  byte address (PC for fetch)
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_fault  out  1  valid with resp_valid
- resp_instr  out  32  latched instruction; held until next fetch completes
- resp_rdata  out  64  extended load data; held until next load completes
- MemRead, MemWrite, IorD  out  1 each  memory controls
- pc_addr, data_addr  out  64 each  memory addresses
- mem_wdata  out  64  memory write data
- mem_instr  in  32  memory instruction output (combinational)
- mem_rdata  in  64  memory data output (combinational)

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0 except req_ready=1.
- States and transitions:
  - IDLE -> FETCH, LOAD, STORE_RD or STORE_WR when req_valid is accepted; -> DONE if a fault is detected at accept.
  - FETCH -> DONE. LOAD -> DONE. STORE_RD -> STORE_WR. STORE_WR -> DONE. DONE -> IDLE.
- Accept: the request is captured into internal registers in IDLE when req_valid=1. Inputs are ignored in all other states.
- Fault checks at accept; a faulted request goes directly to DONE with no memory strobes:
  - Fetch faults if addr[1:0]!=0 or addr>MEM_SIZE-4.
  - Load/store faults if addr>MEM_SIZE-8 (the memory reads/writes 8 bytes) or the access is not naturally aligned for its width.
  - Store faults if addr<TEXT_SIZE.
  - Faults on op=11, load funct3=111, or store funct3[2]=1.
- FETCH: MemRead=1, IorD=0, pc_addr=addr; mem_instr is captured into resp_instr at the clock edge.
- LOAD: MemRead=1, IorD=1, data_addr=addr.
  - Byte 0..(width-1) of mem_rdata is extended and captured into resp_rdata.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD passes through.
- Stores:
  - SD skips STORE_RD.
  - SB/SH/SW: STORE_RD asserts MemRead=1, IorD=1 and captures mem_rdata into an old-data register.
  - STORE_WR: MemWrite=1, IorD=1, mem_wdata = old data with the low 1/2/4 bytes replaced by req_wdata.
  - The memory commits at the edge ending STORE_WR.
- MemRead and MemWrite are never high together. Both are 0 in IDLE and DONE.
- DONE: resp_valid=1 for exactly one cycle.
  - resp_fault=1 for a faulted request, otherwise 0.
  - A faulted load leaves resp_rdata unchanged.
- Latency from accept edge to resp_valid cycle:
  - fetch/load: 2 cycles
  - SD: 2 cycles
  - SB/SH/SW: 3 cycles
  - fault: 1 cycle
- Back-to-back: the next request can be accepted in the cycle after DONE; throughput is 1 request per latency+1 cycles.
- Reset mid-transaction aborts immediately and returns to IDLE. A store aborted before its STORE_WR edge leaves memory unmodified.

Decomposition:
- Shared package (riscv_mem_pkg):
  - state encoding.
  - req_op codes.
  - funct3 constants (LB..LWU, SB..SD).
- One natural sub-module: load_extend (combinational), which takes funct3 and a 64-bit raw value and returns the extended 64-bit result. It is reused by the datapath writeback.

Test Plan:
- Fetch at addr 0x0, memory word 0x00500093 -> resp_valid 2 cycles after accept, resp_instr=0x00500093, fault=0, IorD=0 during FETCH.
- LB at 0x1000, byte 0x80 -> resp_rdata=0xFFFFFFFFFFFFFF80. LBU at the same address -> 0x0000000000000080.
- SB 0xAB to 0x1008, over existing bytes 0x1122334455667788 -> 3-cycle latency; reading LD 0x1008 afterwards returns 0x11223344556677AB.
- SD to 0x0FF8 (text region) -> fault=1 at 1-cycle latency, no MemWrite pulse. LW at 0x1002 -> fault=1.
- LD at 0x2FF8 (MEM_SIZE-8) succeeds; LD at 0x2FF9 faults. Fetch at 0x2FFC succeeds.
- Assert reset during STORE_RD of an SW to 0x1010 -> IDLE and req_ready=1 immediately; memory at 0x1010 unchanged.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the multi-cycle memory access sequencer:
// FSM states, request opcodes and RV64 load/store width codes.
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStoreRd,
    StStoreWr,
    StDone
  } state_e;

  localparam logic [1:0] OpFetch = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Ld  = 3'b011;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Lwu = 3'b110;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;
  localparam logic [2:0] F3Sd  = 3'b011;

  // size: 0 byte, 1 half, 2 word, 3 doubleword
  function automatic logic misaligned(logic [1:0] size, logic [2:0] lsb);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lsb[0];
      2'd2:    return |lsb[1:0];
      default: return |lsb;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of the low bytes of a raw 64-bit load value by RV64 funct3.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] raw,
  output logic [63:0] ext
);

  always_comb begin
    ext = raw;
    case (funct3)
      F3Lb:    ext = {{56{raw[7]}}, raw[7:0]};
      F3Lh:    ext = {{48{raw[15]}}, raw[15:0]};
      F3Lw:    ext = {{32{raw[31]}}, raw[31:0]};
      F3Lbu:   ext = {56'd0, raw[7:0]};
      F3Lhu:   ext = {48'd0, raw[15:0]};
      F3Lwu:   ext = {32'd0, raw[31:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle sequencer serialising fetches, loads and read-modify-write stores
// onto a single-port unified memory that always transfers 8 bytes.
module mem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 12288,
  parameter int unsigned TEXT_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] resp_instr,
  output logic [63:0] resp_rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic [63:0] pc_addr,
  output logic [63:0] data_addr,
  output logic [63:0] mem_wdata,
  input  logic [31:0] mem_instr,
  input  logic [63:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q, wdata_q, old_q;
  logic        fault_q;
  logic [31:0] instr_q;
  logic [63:0] rdata_q;
  logic        accept_fault;
  logic        data_range_bad;
  logic [63:0] load_ext;
  logic [63:0] merged;

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .raw    (mem_rdata),
    .ext    (load_ext)
  );

  // Data accesses span 8 bytes regardless of width, so the range limit is MEM_SIZE-8.
  assign data_range_bad = req_addr > 64'(MEM_SIZE - 8);

  always_comb begin
    accept_fault = 1'b0;
    case (req_op)
      OpFetch: accept_fault = (req_addr[1:0] != 2'b00) || (req_addr > 64'(MEM_SIZE - 4));
      OpLoad:  accept_fault = (req_funct3 == 3'b111) || data_range_bad ||
                              misaligned(req_funct3[1:0], req_addr[2:0]);
      OpStore: accept_fault = req_funct3[2] || data_range_bad ||
                              misaligned(req_funct3[1:0], req_addr[2:0]) ||
                              (req_addr < 64'(TEXT_SIZE));
      default: accept_fault = 1'b1;
    endcase
  end

  always_comb begin
    merged = wdata_q;
    case (funct3_q[1:0])
      2'd0:    merged = {old_q[63:8], wdata_q[7:0]};
      2'd1:    merged = {old_q[63:16], wdata_q[15:0]};
      2'd2:    merged = {old_q[63:32], wdata_q[31:0]};
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    pc_addr   = '0;
    data_addr = '0;
    mem_wdata = '0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (accept_fault) begin
            state_d = StDone;
          end else if (req_op == OpFetch) begin
            state_d = StFetch;
          end else if (req_op == OpLoad) begin
            state_d = StLoad;
          end else if (req_funct3 == F3Sd) begin
            state_d = StStoreWr;
          end else begin
            state_d = StStoreRd;
          end
        end
      end
      StFetch: begin
        MemRead = 1'b1;
        pc_addr = addr_q;
        state_d = StDone;
      end
      StLoad: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        data_addr = addr_q;
        state_d   = StDone;
      end
      StStoreRd: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        data_addr = addr_q;
        state_d   = StStoreWr;
      end
      StStoreWr: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        data_addr = addr_q;
        mem_wdata = merged;
        state_d   = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      fault_q  <= 1'b0;
      instr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            fault_q  <= accept_fault;
          end
        end
        StFetch:   instr_q <= mem_instr;
        StLoad:    rdata_q <= load_ext;
        StStoreRd: old_q   <= mem_rdata;
        default:   ;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign resp_fault = (state_q == StDone) && fault_q;
  assign resp_instr = instr_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-array model of the unified memory.
module tb_mem_access_ctrl;

  localparam int unsigned MemSize = 12288;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_instr;
  logic [63:0] resp_rdata;
  logic        MemRead, MemWrite, IorD;
  logic [63:0] pc_addr, data_addr, mem_wdata;
  logic [31:0] mem_instr;
  logic [63:0] mem_rdata;

  logic [7:0]  mem [0:MemSize-1];

  int n_checks = 0;
  int n_errors = 0;
  int overlap = 0;

  mem_access_ctrl #(.MEM_SIZE(12288), .TEXT_SIZE(4096)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_fault (resp_fault),
    .resp_instr (resp_instr),
    .resp_rdata (resp_rdata),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .pc_addr    (pc_addr),
    .data_addr  (data_addr),
    .mem_wdata  (mem_wdata),
    .mem_instr  (mem_instr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = '0;
    if (data_addr <= 64'(MemSize - 8))
      for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[int'(data_addr[13:0]) + i];
  end

  always_comb begin
    mem_instr = '0;
    if (pc_addr <= 64'(MemSize - 4))
      for (int i = 0; i < 4; i++) mem_instr[8*i +: 8] = mem[int'(pc_addr[13:0]) + i];
  end

  always @(posedge clk) begin
    if (MemWrite && data_addr <= 64'(MemSize - 8))
      for (int i = 0; i < 8; i++) mem[int'(data_addr[13:0]) + i] <= mem_wdata[8*i +: 8];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put64(input int a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[a + i] <= v[8*i +: 8];
  endtask

  // Issues one request and returns edges from the accept edge to resp_valid (0 on timeout).
  task automatic do_req(input logic [1:0] op, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output int lat, output logic flt,
                        output logic wrote, output logic iord_seen);
    int guard = 0;
    lat = 0; flt = 1'b0; wrote = 1'b0; iord_seen = 1'b0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_op = op; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) req_valid = 1'b0;
      wrote = wrote | MemWrite;
      if (MemRead) iord_seen = iord_seen | IorD;
      if (MemRead && MemWrite) overlap++;
      if (resp_valid) begin
        lat = n;
        flt = resp_fault;
        break;
      end
    end
  endtask

  int   lat;
  logic flt, wrote, iord;

  initial begin
    for (int i = 0; i < MemSize; i++) mem[i] <= 8'h00;
    #1;
    put64(32'h0000, 64'h0000_0000_0050_0093);
    put64(32'h1000, 64'h0102_0304_0506_0780);
    put64(32'h1008, 64'h1122_3344_5566_7788);
    put64(32'h1010, 64'hDEAD_BEEF_CAFE_F00D);
    put64(32'h2FF8, 64'hCAFE_BABE_1234_5678);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
    check("rst_instr", 64'(resp_instr), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    do_req(2'b00, 3'b010, 64'h0, 64'h0, lat, flt, wrote, iord);
    check("fetch0_lat", 64'(lat), 64'd2);
    check("fetch0_fault", 64'(flt), 64'd0);
    check("fetch0_iord", 64'(iord), 64'd0);
    check("fetch0_instr", 64'(resp_instr), 64'h0050_0093);

    do_req(2'b01, 3'b000, 64'h1000, 64'h0, lat, flt, wrote, iord);
    check("lb_lat", 64'(lat), 64'd2);
    check("lb_iord", 64'(iord), 64'd1);
    check("lb_data", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("instr_held", 64'(resp_instr), 64'h0050_0093);
    do_req(2'b01, 3'b100, 64'h1000, 64'h0, lat, flt, wrote, iord);
    check("lbu_data", resp_rdata, 64'h0000_0000_0000_0080);

    do_req(2'b10, 3'b000, 64'h1008, 64'hAB, lat, flt, wrote, iord);
    check("sb_lat", 64'(lat), 64'd3);
    check("sb_fault", 64'(flt), 64'd0);
    check("sb_wrote", 64'(wrote), 64'd1);
    do_req(2'b01, 3'b011, 64'h1008, 64'h0, lat, flt, wrote, iord);
    check("ld_after_sb", resp_rdata, 64'h1122_3344_5566_77AB);

    do_req(2'b10, 3'b011, 64'h0FF8, 64'h1234, lat, flt, wrote, iord);
    check("sd_text_fault", 64'(flt), 64'd1);
    check("sd_text_lat", 64'(lat), 64'd1);
    check("sd_text_nowrite", 64'(wrote), 64'd0);
    do_req(2'b01, 3'b010, 64'h1002, 64'h0, lat, flt, wrote, iord);
    check("lw_mis_fault", 64'(flt), 64'd1);
    check("lw_mis_rdata_held", resp_rdata, 64'h1122_3344_5566_77AB);

    do_req(2'b01, 3'b011, 64'h2FF8, 64'h0, lat, flt, wrote, iord);
    check("ld_top_fault", 64'(flt), 64'd0);
    check("ld_top_data", resp_rdata, 64'hCAFE_BABE_1234_5678);
    do_req(2'b01, 3'b011, 64'h2FF9, 64'h0, lat, flt, wrote, iord);
    check("ld_over_fault", 64'(flt), 64'd1);
    check("ld_over_held", resp_rdata, 64'hCAFE_BABE_1234_5678);
    do_req(2'b00, 3'b010, 64'h2FFC, 64'h0, lat, flt, wrote, iord);
    check("fetch_top_fault", 64'(flt), 64'd0);
    check("fetch_top_instr", 64'(resp_instr), 64'hCAFE_BABE);

    // Abort an SW during its read phase.
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_funct3 = 3'b010;
    req_addr = 64'h1010; req_wdata = 64'h5555_5555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("sw_in_rd", {62'd0, MemRead, req_ready}, 64'd2);
    reset = 1'b0;
    #1;
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    do_req(2'b01, 3'b011, 64'h1010, 64'h0, lat, flt, wrote, iord);
    check("abort_mem_kept", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);

    check("rd_wr_overlap", 64'(overlap), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
